// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the register file
package regfile_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] reg_data_t;
    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port, optional write bypass (REGISTER_FILE_WRITE_BYPASS_EN)
module regfile_read_port #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] regs_i [2**ADDR_WIDTH],
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
`endif
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    import regfile_pkg::*;

    // Select the stored word, or forward the in-flight write when bypass is built in
    always_comb begin
        rd_data_o = regs_i[rd_addr_i];
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
        if (wr_en_i && !rst_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_o = wr_data_i;
        end
`endif
    end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 2-read/1-write register file; macro REGISTER_FILE_WRITE_BYPASS_EN enables write-to-read bypass
module register_file #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write_en,
    input  logic [ADDR_WIDTH-1:0] reg_write_dest,
    input  logic [DATA_WIDTH-1:0] reg_write_data,
    input  logic [ADDR_WIDTH-1:0] reg_read_addr_1,
    output logic [DATA_WIDTH-1:0] reg_read_data_1,
    input  logic [ADDR_WIDTH-1:0] reg_read_addr_2,
    output logic [DATA_WIDTH-1:0] reg_read_data_2
);
    import regfile_pkg::*;

    localparam int NumEntries = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NumEntries];
    logic [DATA_WIDTH-1:0] regs_d [NumEntries];

    // Next state: only the addressed register changes, and only when enabled
    always_comb begin
        regs_d = regs_q;
        if (reg_write_en) begin
            regs_d[reg_write_dest] = reg_write_data;
        end
    end

    // Storage: reset wins over a same-edge write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumEntries; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_port_1 (
        .regs_i    (regs_q),
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
        .rst_i     (rst),
        .wr_en_i   (reg_write_en),
        .wr_addr_i (reg_write_dest),
        .wr_data_i (reg_write_data),
`endif
        .rd_addr_i (reg_read_addr_1),
        .rd_data_o (reg_read_data_1)
    );

    regfile_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_port_2 (
        .regs_i    (regs_q),
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
        .rst_i     (rst),
        .wr_en_i   (reg_write_en),
        .wr_addr_i (reg_write_dest),
        .wr_data_i (reg_write_data),
`endif
        .rd_addr_i (reg_read_addr_2),
        .rd_data_o (reg_read_data_2)
    );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard testbench for register_file
module tb_register_file;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b0;
    logic      reg_write_en = 1'b0;
    reg_addr_t reg_write_dest = '0;
    reg_data_t reg_write_data = '0;
    reg_addr_t reg_read_addr_1 = '0;
    reg_data_t reg_read_data_1;
    reg_addr_t reg_read_addr_2 = '0;
    reg_data_t reg_read_data_2;

    register_file dut (
        .clk             (clk),
        .rst             (rst),
        .reg_write_en    (reg_write_en),
        .reg_write_dest  (reg_write_dest),
        .reg_write_data  (reg_write_data),
        .reg_read_addr_1 (reg_read_addr_1),
        .reg_read_data_1 (reg_read_data_1),
        .reg_read_addr_2 (reg_read_addr_2),
        .reg_read_data_2 (reg_read_data_2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string     tag;
        reg_addr_t a1;
        reg_addr_t a2;
        reg_data_t e1;
        reg_data_t e2;
    } exp_t;

    exp_t      exp_q[$];
    reg_data_t model_mem [NUM_REGS];
    int        checks = 0;
    int        errors = 0;
    bit        done = 1'b0;

    // Expected read value for the cycle being presented, before the edge
    function automatic reg_data_t model_read(input reg_addr_t a, input logic r, input logic we,
                                             input reg_addr_t dest, input reg_data_t d);
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
        if (we && !r && a == dest) return d;
`endif
        return model_mem[a];
    endfunction

    task automatic drive(input logic r, input logic we, input reg_addr_t dest, input reg_data_t d,
                         input reg_addr_t a1, input reg_addr_t a2, input bit chk, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        reg_write_en = we;
        reg_write_dest = dest;
        reg_write_data = d;
        reg_read_addr_1 = a1;
        reg_read_addr_2 = a2;
        if (chk) begin
            e.tag = tag;
            e.a1 = a1;
            e.a2 = a2;
            e.e1 = model_read(a1, r, we, dest, d);
            e.e2 = model_read(a2, r, we, dest, d);
            exp_q.push_back(e);
        end
        // State the register file will hold after the coming edge
        if (r) begin
            for (int i = 0; i < NUM_REGS; i++) model_mem[i] = '0;
        end else if (we) begin
            model_mem[dest] = d;
        end
    endtask

    // Monitor: compare combinational outputs mid-cycle against queued expectations
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (reg_read_data_1 !== e.e1) begin
                    errors++;
                    $display("FAIL %s port1 addr=%0h got=%h exp=%h", e.tag, e.a1, reg_read_data_1, e.e1);
                end
                checks++;
                if (reg_read_data_2 !== e.e2) begin
                    errors++;
                    $display("FAIL %s port2 addr=%0h got=%h exp=%h", e.tag, e.a2, reg_read_data_2, e.e2);
                end
            end
        end
    end

    initial begin
        reg_addr_t ra, rb, rd;
        reg_data_t rdat;
        logic      rr, rw;

        for (int i = 0; i < NUM_REGS; i++) model_mem[i] = '0;

        // Reset, then sweep both ports over every address
        drive(1, 0, 4'h0, 16'h0000, 4'h0, 4'h0, 0, "rst");
        for (int i = 0; i < NUM_REGS; i++)
            drive(0, 0, 4'h0, 16'h0000, reg_addr_t'(i), reg_addr_t'(15 - i), 1, "reset_sweep");

        // Single write, then read it back on both ports and check the rest stayed clear
        drive(0, 1, 4'h3, 16'hA5A5, 4'h0, 4'h1, 1, "wr3_pre");
        drive(0, 0, 4'h0, 16'h0000, 4'h3, 4'h3, 1, "wr3_read");
        for (int i = 0; i < NUM_REGS; i++)
            drive(0, 0, 4'h0, 16'h0000, reg_addr_t'(i), 4'h3, 1, "wr3_others");

        // Disabled write must not land
        drive(0, 0, 4'h5, 16'h1234, 4'h5, 4'h5, 1, "en_off");
        drive(0, 0, 4'h0, 16'h0000, 4'h5, 4'h5, 1, "en_off_read");

        // Reset beats a same-edge write
        drive(0, 1, 4'hF, 16'hFFFF, 4'hF, 4'h0, 1, "rstprio_load");
        drive(0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 1, "rstprio_loaded");
        drive(1, 1, 4'hF, 16'h5555, 4'hF, 4'hF, 1, "rstprio_edge");
        drive(0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 1, "rstprio_after");

        // Read of the register being written in the same cycle
        drive(0, 1, 4'h7, 16'h1111, 4'h0, 4'h0, 1, "same_seed");
        drive(0, 1, 4'h7, 16'h00C3, 4'h7, 4'h7, 1, "same_cycle");
        drive(0, 0, 4'h0, 16'h0000, 4'h7, 4'h7, 1, "same_after");

        // Full sweep with distinct values, register 0 included
        for (int i = 0; i < NUM_REGS; i++)
            drive(0, 1, reg_addr_t'(i), reg_data_t'(16'h1000 + i), 4'h0, 4'hF, 1, "sweep_wr");
        for (int i = 0; i < NUM_REGS; i++)
            drive(0, 0, 4'h0, 16'h0000, reg_addr_t'(i), reg_addr_t'(15 - i), 1, "sweep_rd");

        // Randomised traffic including occasional mid-run resets
        for (int n = 0; n < 400; n++) begin
            rr   = ($urandom_range(0, 24) == 0);
            rw   = ($urandom_range(0, 2) != 0);
            rd   = reg_addr_t'($urandom_range(0, 15));
            rdat = reg_data_t'($urandom);
            ra   = ($urandom_range(0, 3) == 0) ? rd : reg_addr_t'($urandom_range(0, 15));
            rb   = ($urandom_range(0, 3) == 0) ? ra : reg_addr_t'($urandom_range(0, 15));
            drive(rr, rw, rd, rdat, ra, rb, 1, "random");
        end

        drive(0, 0, 4'h0, 16'h0000, 4'h0, 4'h0, 0, "idle");

        // Bounded drain of outstanding expectations
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the width of each register and data port.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, meaning the address width; the register count is 2**ADDR_WIDTH (16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port reg_write_en, input, 1 bit: write enable.
REQ-006 The block SHALL have port reg_write_dest, input, ADDR_WIDTH: write address.
REQ-007 The block SHALL have port reg_write_data, input, DATA_WIDTH: write data.
REQ-008 The block SHALL have port reg_read_addr_1, input, ADDR_WIDTH: read port 1 address.
REQ-009 The block SHALL have port reg_read_data_1, output, DATA_WIDTH: read port 1 data.
REQ-010 The block SHALL have port reg_read_addr_2, input, ADDR_WIDTH: read port 2 address.
REQ-011 The block SHALL have port reg_read_data_2, output, DATA_WIDTH: read port 2 data.
REQ-012 Port order SHALL be: clk, rst, reg_write_en, reg_write_dest, reg_write_data, reg_read_addr_1, reg_read_data_1, reg_read_addr_2, reg_read_data_2.

Function
REQ-013 The block SHALL hold 16 general registers of DATA_WIDTH bits, indexed 0x0 to 0xF.
REQ-014 Both read ports SHALL be combinational: reg_read_data_N reflects the register at reg_read_addr_N within the same cycle, with zero clock latency.
REQ-015 A write SHALL occur on the rising clk edge when reg_write_en=1 and rst=0; the register at reg_write_dest takes reg_write_data.
REQ-016 With reg_write_en=0, no register SHALL change.
REQ-017 Both ports addressing the same register SHALL return identical data.
REQ-018 With the macro in REQ-023 absent, a read of the address being written SHALL return the old value until the edge, and the new value after it.
REQ-019 Every address 0x0 to 0xF SHALL be writable, including register 0, which has no hard-wired value.

Reset
REQ-020 On a rising clk edge with rst=1, all 16 registers SHALL become 0x0000, so both read outputs show 0x0000 for any address after that edge.
REQ-021 Reset SHALL take priority over a same-edge write; the write is discarded.
REQ-022 Reset asserted mid-operation SHALL clear every register at the next edge, regardless of prior contents.

Configuration
REQ-023 When macro REGISTER_FILE_WRITE_BYPASS_EN is defined, a read port SHALL return reg_write_data combinationally whenever reg_write_en=1, rst=0 and its address equals reg_write_dest.
REQ-024 When REGISTER_FILE_WRITE_BYPASS_EN is not defined, read data SHALL come only from stored register contents, per REQ-018.

Structure
REQ-025 A shared package regfile_pkg SHALL define the constants DATA_WIDTH=16, ADDR_WIDTH=4 and NUM_REGS=16, plus the typedefs reg_data_t and reg_addr_t.
REQ-026 One sub-module, regfile_read_port, SHALL implement a single read port, including the optional bypass mux, and SHALL be instantiated twice; storage and write logic stay in register_file.

Verification
REQ-027 Reset scenario: apply rst=1 for one edge, then sweep both read addresses 0x0 to 0xF -> every read returns 0x0000.
REQ-028 Write/read scenario: write 0xA5A5 to register 0x3, then set reg_read_addr_1=3 and reg_read_addr_2=3 after the edge -> both ports return 0xA5A5, and all other registers still read 0x0000.
REQ-029 Enable scenario: present reg_write_en=0 with dest=0x5 and data=0x1234 -> register 0x5 stays 0x0000.
REQ-030 Reset-priority scenario: load 0xFFFF into register 0xF, then assert rst=1 and reg_write_en=1 with data=0x5555 on the same edge -> register 0xF reads 0x0000.
REQ-031 Same-cycle scenario: write 0x00C3 to register 0x7 while reg_read_addr_1=7 -> before the edge, reads the old value without REGISTER_FILE_WRITE_BYPASS_EN, or 0x00C3 with it.
REQ-032 Full-sweep scenario: write register i with 0x1000+i for i=0 to 15, then read port 1 with i and port 2 with 15-i -> port 1 returns 0x1000+i and port 2 returns 0x100F-i.
